multi_sprite_blob: RTL and testbench

MULTI_SPRITE_BLOB -- requirements
Module: multi_sprite_blob

---
 rtl/sprite_pkg.sv | 46 ++++
 rtl/sprite_palette.sv | 27 ++
 rtl/multi_sprite_blob.sv | 212 +++++++++++++++++++++
 tb/tb_multi_sprite_blob.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite codes, pose/address helpers and the fixed palette for the sprite renderer.
package sprite_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CHOPPING  = 4'd1,
    ST_WALKING   = 4'd2,
    ST_RUNNING   = 4'd3,
    ST_CARRYING  = 4'd4,
    ST_ATTACKING = 4'd5,
    ST_HURT      = 4'd6,
    ST_DYING     = 4'd7,
    ST_DEAD      = 4'd8,
    ST_JUMPING   = 4'd9,
    ST_SITTING   = 4'd10
  } state_e;

  localparam int          POSE_W        = 6;
  localparam logic [11:0] OUTLINE_COLOR = 12'hF00;

  function automatic int pose_width();
    return POSE_W;
  endfunction

  // Address layout is {pose, frame, row, column}.
  function automatic int addr_width(input int num_frames, input int height, input int width);
    return pose_width() + $clog2(num_frames) + $clog2(height) + $clog2(width);
  endfunction

  function automatic logic [POSE_W-1:0] make_pose(input logic [3:0] state, input logic [1:0] dir);
    return {state, dir};
  endfunction

  // Fixed 8-bit index to 4:4:4 colour mapping: high nibble red, low nibble green, inverted low nibble blue.
  function automatic logic [11:0] palette_rgb(input logic [7:0] idx);
    return {idx, ~idx[3:0]};
  endfunction

endpackage

// File: rtl/sprite_palette.sv
// Registered 256-entry palette lookup: 8-bit colour index in, 12-bit RGB out one cycle later.
module sprite_palette
  import sprite_pkg::*;
(
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic [7:0]  color_idx,
  output logic [11:0] rgb
);

  logic [11:0] palette_rom [256];

  generate
    for (genvar gi = 0; gi < 256; gi++) begin : g_rom
      assign palette_rom[gi] = palette_rgb(8'(gi));
    end
  endgenerate

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rgb <= '0;
    end else begin
      rgb <= palette_rom[color_idx];
    end
  end

endmodule

// File: rtl/multi_sprite_blob.sv
// Multi-sprite renderer: frame-synchronous shadows, per-sprite ROM addressing, priority composite.
// Build option: define SPRITE_OUTLINE_EN to draw a red border around every sprite box.
module multi_sprite_blob
  import sprite_pkg::*;
#(
  parameter int          NUM_SPRITES     = 2,
  parameter int          WIDTH           = 32,
  parameter int          HEIGHT          = 32,
  parameter int          NUM_FRAMES      = 2,
  parameter int          FRAME_PERIOD    = 8,
  parameter int          ROM_LAT         = 2,
  parameter logic [7:0]  TRANSPARENT_IDX = 8'h00,
  parameter logic [11:0] BG_COLOR        = 12'hFFF
) (
  input  logic                                                     pixel_clk_in,
  input  logic                                                     rst_n_in,
  input  logic                                                     vsync_in,
  input  logic [10:0]                                              hcount_in,
  input  logic [9:0]                                               vcount_in,
  input  logic [NUM_SPRITES*11-1:0]                                x_in,
  input  logic [NUM_SPRITES*10-1:0]                                y_in,
  input  logic [NUM_SPRITES*2-1:0]                                 dir_in,
  input  logic [NUM_SPRITES*4-1:0]                                 state_in,
  output logic [NUM_SPRITES*addr_width(NUM_FRAMES,HEIGHT,WIDTH)-1:0] rom_addr_out,
  input  logic [NUM_SPRITES*8-1:0]                                 rom_data_in,
  output logic [11:0]                                              pixel_out,
  output logic                                                     hit_out
);

  localparam int          XB        = $clog2(WIDTH);
  localparam int          YB        = $clog2(HEIGHT);
  localparam int          FB        = $clog2(NUM_FRAMES);
  localparam int          AW        = addr_width(NUM_FRAMES, HEIGHT, WIDTH);
  localparam logic [11:0] W12       = 12'(WIDTH);
  localparam logic [11:0] H12       = 12'(HEIGHT);
  localparam logic [15:0] TICK_LAST = 16'(FRAME_PERIOD - 1);

  logic        vs_prev_reg;
  logic        vs_edge_reg;
  logic [15:0] tick_reg;
  logic        tick_wrap;

  assign tick_wrap = vs_edge_reg && (tick_reg == TICK_LAST);

  // Edge history resets high so a vsync already high at release is not a new frame.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vs_prev_reg <= 1'b1;
      vs_edge_reg <= 1'b0;
      tick_reg    <= '0;
    end else begin
      vs_prev_reg <= vsync_in;
      vs_edge_reg <= vsync_in & ~vs_prev_reg;
      if (vs_edge_reg) begin
        tick_reg <= tick_wrap ? '0 : tick_reg + 16'd1;
      end
    end
  end

  logic [11:0]            h12;
  logic [11:0]            v12;
  logic [NUM_SPRITES-1:0] opaque_d;

  assign h12 = {1'b0, hcount_in};
  assign v12 = {2'b00, vcount_in};

`ifdef SPRITE_OUTLINE_EN
  logic [NUM_SPRITES-1:0] border_d;
`endif

  generate
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
      logic [10:0]       x_reg;
      logic [9:0]        y_reg;
      logic [1:0]        dir_reg;
      logic [3:0]        state_reg;
      logic [FB-1:0]     frame_reg;
      logic [10:0]       x_new;
      logic [9:0]        y_new;
      logic [3:0]        state_new;
      logic              animate;
      logic [11:0]       x12;
      logic [11:0]       y12;
      logic [XB-1:0]     dx;
      logic [YB-1:0]     dy;
      logic              inbox_now;
      logic [AW-1:0]     addr_reg;
      logic [ROM_LAT:0]  inbox_pipe;

      assign x_new     = x_in[gi*11 +: 11];
      assign y_new     = y_in[gi*10 +: 10];
      assign state_new = state_in[gi*4 +: 4];
      // Movement is judged against the previous shadow, using the value being captured now.
      assign animate   = (x_new != x_reg) || (y_new != y_reg) || (state_new == 4'(ST_CHOPPING));

      always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          x_reg     <= '0;
          y_reg     <= '0;
          dir_reg   <= '0;
          state_reg <= '0;
          frame_reg <= '0;
        end else if (vs_edge_reg) begin
          x_reg     <= x_new;
          y_reg     <= y_new;
          dir_reg   <= dir_in[gi*2 +: 2];
          state_reg <= state_new;
          if (tick_wrap) begin
            frame_reg <= animate ? frame_reg + FB'(1) : '0;
          end
        end
      end

      assign x12       = {1'b0, x_reg};
      assign y12       = {2'b00, y_reg};
      assign dx        = XB'(h12 - x12);
      assign dy        = YB'(v12 - y12);
      assign inbox_now = (h12 >= x12) && (h12 < x12 + W12) && (v12 >= y12) && (v12 < y12 + H12);

      always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          addr_reg   <= '0;
          inbox_pipe <= '0;
        end else begin
          addr_reg   <= inbox_now ? {make_pose(state_reg, dir_reg), frame_reg, dy, dx} : '0;
          inbox_pipe <= {inbox_pipe[ROM_LAT-1:0], inbox_now};
        end
      end

      assign rom_addr_out[gi*AW +: AW] = addr_reg;

`ifdef SPRITE_OUTLINE_EN
      logic             border_now;
      logic [ROM_LAT:0] border_pipe;

      assign border_now = inbox_now && ((dx == '0) || (dx == XB'(WIDTH - 1)) ||
                                        (dy == '0) || (dy == YB'(HEIGHT - 1)));

      always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          border_pipe <= '0;
        end else begin
          border_pipe <= {border_pipe[ROM_LAT-1:0], border_now};
        end
      end

      assign border_d[gi] = border_pipe[ROM_LAT];
      assign opaque_d[gi] = inbox_pipe[ROM_LAT] &&
                            (border_pipe[ROM_LAT] || (rom_data_in[gi*8 +: 8] != TRANSPARENT_IDX));
`else
      assign opaque_d[gi] = inbox_pipe[ROM_LAT] && (rom_data_in[gi*8 +: 8] != TRANSPARENT_IDX);
`endif
    end
  endgenerate

  logic [7:0]  win_idx;
  logic        win_hit;
  logic        hit_reg;
  logic [11:0] pal_rgb;

`ifdef SPRITE_OUTLINE_EN
  logic win_border;
  logic border_reg;
`endif

  // Walk from the highest index down so the lowest opaque sprite is the last to write.
  always_comb begin
    win_idx = TRANSPARENT_IDX;
    win_hit = 1'b0;
`ifdef SPRITE_OUTLINE_EN
    win_border = 1'b0;
`endif
    for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
      if (opaque_d[s]) begin
        win_idx = rom_data_in[s*8 +: 8];
        win_hit = 1'b1;
`ifdef SPRITE_OUTLINE_EN
        win_border = border_d[s];
`endif
      end
    end
  end

  sprite_palette u_palette (
    .pixel_clk_in (pixel_clk_in),
    .rst_n_in     (rst_n_in),
    .color_idx    (win_idx),
    .rgb          (pal_rgb)
  );

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hit_reg <= 1'b0;
`ifdef SPRITE_OUTLINE_EN
      border_reg <= 1'b0;
`endif
    end else begin
      hit_reg <= win_hit;
`ifdef SPRITE_OUTLINE_EN
      border_reg <= win_border;
`endif
    end
  end

  assign hit_out = hit_reg;
`ifdef SPRITE_OUTLINE_EN
  assign pixel_out = !hit_reg ? BG_COLOR : (border_reg ? OUTLINE_COLOR : pal_rgb);
`else
  assign pixel_out = hit_reg ? pal_rgb : BG_COLOR;
`endif

endmodule

// File: tb/tb_multi_sprite_blob.sv
// Scoreboard bench for multi_sprite_blob: a behavioural model queues expected pixels per raster input.
module tb_multi_sprite_blob;

  localparam int          NS     = 2;
  localparam int          W      = 32;
  localparam int          H      = 32;
  localparam int          FP     = 8;
  localparam int          RL     = 2;
  localparam int          L      = RL + 2;
  localparam int          AW     = 17;
  localparam int          IDLE_H = 1500;
  localparam int          IDLE_V = 900;
  localparam logic [11:0] BG     = 12'hFFF;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             vsync;
  logic [10:0]      hcount;
  logic [9:0]       vcount;
  logic [NS*11-1:0] x_bus;
  logic [NS*10-1:0] y_bus;
  logic [NS*2-1:0]  dir_bus;
  logic [NS*4-1:0]  state_bus;
  logic [NS*AW-1:0] addr_bus;
  logic [NS*8-1:0]  data_bus;
  logic [11:0]      pixel;
  logic             hit;

  always #5 clk = ~clk;

  multi_sprite_blob #(
    .NUM_SPRITES(NS), .WIDTH(W), .HEIGHT(H), .NUM_FRAMES(2), .FRAME_PERIOD(FP),
    .ROM_LAT(RL), .TRANSPARENT_IDX(8'h00), .BG_COLOR(BG)
  ) dut (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .vsync_in     (vsync),
    .hcount_in    (hcount),
    .vcount_in    (vcount),
    .x_in         (x_bus),
    .y_in         (y_bus),
    .dir_in       (dir_bus),
    .state_in     (state_bus),
    .rom_addr_out (addr_bus),
    .rom_data_in  (data_bus),
    .pixel_out    (pixel),
    .hit_out      (hit)
  );

  int         in_x [NS];
  int         in_y [NS];
  logic [1:0] in_dir [NS];
  logic [3:0] in_st [NS];
  logic [7:0] rom_base [NS];

  int         m_x [NS];
  int         m_y [NS];
  logic [1:0] m_dir [NS];
  logic [3:0] m_st [NS];
  logic       m_frame [NS];
  int         m_tick;

  logic [AW-1:0] rom_pipe [NS][RL];

  // Bench ROM: word = per-sprite base + column offset, returned RL cycles after the address.
  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_tb
      assign x_bus[gi*11 +: 11]   = 11'(in_x[gi]);
      assign y_bus[gi*10 +: 10]   = 10'(in_y[gi]);
      assign dir_bus[gi*2 +: 2]   = in_dir[gi];
      assign state_bus[gi*4 +: 4] = in_st[gi];
      always @(posedge clk) begin
        rom_pipe[gi][0] <= addr_bus[gi*AW +: AW];
        for (int i = 1; i < RL; i++) rom_pipe[gi][i] <= rom_pipe[gi][i-1];
      end
      assign data_bus[gi*8 +: 8] = rom_base[gi] + {3'b000, rom_pipe[gi][RL-1][4:0]};
    end
  endgenerate

  typedef struct {
    int          h;
    int          v;
    logic [11:0] pix;
    logic        hit;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] last_a [NS];
  logic [AW-1:0] obs_a [NS];
  bit            have_last;
  bit            check_bg;
  int            n_tests;
  int            n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_in(input int s, input int h, input int v);
    return (h >= m_x[s]) && (h < m_x[s] + W) && (v >= m_y[s]) && (v < m_y[s] + H);
  endfunction

  function automatic logic [AW-1:0] m_addr(input int s, input int h, input int v);
    logic [4:0] dx;
    logic [4:0] dy;
    if (!m_in(s, h, v)) return '0;
    dx = 5'(h - m_x[s]);
    dy = 5'(v - m_y[s]);
    return {m_st[s], m_dir[s], m_frame[s], dy, dx};
  endfunction

  function automatic logic [11:0] pal(input logic [7:0] i);
    return {i, 4'hF ^ i[3:0]};
  endfunction

  task automatic push_exp(input int h, input int v);
    exp_t          e;
    logic [AW-1:0] a;
    logic [7:0]    d;
    e.h = h; e.v = v; e.pix = BG; e.hit = 1'b0;
    for (int s = NS - 1; s >= 0; s--) begin
      a = m_addr(s, h, v);
      d = rom_base[s] + {3'b000, a[4:0]};
      if (m_in(s, h, v) && d != 8'h00) begin
        e.pix = pal(d);
        e.hit = 1'b1;
      end
      last_a[s] = a;
    end
    sb.push_back(e);
  endtask

  task automatic step(input int h, input int v);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == L) begin
      e = sb.pop_front();
      check("pixel", 32'(pixel), 32'(e.pix));
      check("hit", 32'(hit), 32'(e.hit));
      $display("[TB] out h=%0d v=%0d pixel=%03h hit=%0b", e.h, e.v, pixel, hit);
      check_bg = 1'b0;
    end else if (check_bg) begin
      check("rst_bg_pixel", 32'(pixel), 32'(BG));
      check("rst_bg_hit", 32'(hit), 32'(0));
    end
    for (int s = 0; s < NS; s++) begin
      obs_a[s] = addr_bus[s*AW +: AW];
      if (have_last) check($sformatf("addr%0d", s), 32'(obs_a[s]), 32'(last_a[s]));
    end
    hcount = 11'(h);
    vcount = 10'(v);
    push_exp(h, v);
    have_last = 1'b1;
  endtask

  task automatic drain();
    repeat (L) step(IDLE_H, IDLE_V);
  endtask

  task automatic do_vsync();
    bit mv [NS];
    drain();
    vsync = 1'b1;
    repeat (3) step(IDLE_H, IDLE_V);
    vsync = 1'b0;
    repeat (3) step(IDLE_H, IDLE_V);
    for (int s = 0; s < NS; s++) begin
      mv[s] = (in_x[s] != m_x[s]) || (in_y[s] != m_y[s]);
      m_x[s] = in_x[s]; m_y[s] = in_y[s]; m_dir[s] = in_dir[s]; m_st[s] = in_st[s];
    end
    if (m_tick == FP - 1) begin
      m_tick = 0;
      for (int s = 0; s < NS; s++) m_frame[s] = (mv[s] || m_st[s] == 4'd1) ? ~m_frame[s] : 1'b0;
    end else begin
      m_tick++;
    end
  endtask

  task automatic probe_frame(input int s, input logic exp_bit, input string tag);
    logic [AW-1:0] a;
    step(m_x[s] + 1, m_y[s] + 1);
    step(IDLE_H, IDLE_V);
    a = obs_a[s];
    check(tag, 32'(a[10]), 32'(exp_bit));
  endtask

  task automatic clear_model();
    for (int s = 0; s < NS; s++) begin
      m_x[s] = 0; m_y[s] = 0; m_dir[s] = '0; m_st[s] = '0; m_frame[s] = 1'b0;
    end
    m_tick = 0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; have_last = 1'b0; check_bg = 1'b1;
    for (int s = 0; s < NS; s++) begin
      in_x[s] = 0; in_y[s] = 0; in_dir[s] = '0; in_st[s] = '0; rom_base[s] = '0;
    end
    clear_model();
    rst_n = 1'b0; vsync = 1'b0;
    hcount = 11'(IDLE_H); vcount = 10'(IDLE_V);
    repeat (3) @(posedge clk);
    #1;
    check("reset_pixel", 32'(pixel), 32'(BG));
    check("reset_hit", 32'(hit), 32'(0));
    for (int s = 0; s < NS; s++) check("reset_addr", 32'(addr_bus[s*AW +: AW]), 32'(0));
    rst_n = 1'b1;

    // Single sprite hit and exact latency, with surrounding misses.
    in_x[0] = 100; in_y[0] = 50;  in_dir[0] = 2'd1; in_st[0] = 4'd2; rom_base[0] = 8'h05;
    in_x[1] = 700; in_y[1] = 300; in_dir[1] = 2'd2; in_st[1] = 4'd3; rom_base[1] = 8'h20;
    do_vsync();
    step(100, 50); step(IDLE_H, IDLE_V); step(131, 81); step(132, 50); step(99, 50); step(710, 310);
    drain();

    // Overlapping sprites: transparent pixel falls through to sprite 1.
    in_x[0] = 200; in_y[0] = 200; in_x[1] = 200; in_y[1] = 200;
    rom_base[0] = 8'h00; rom_base[1] = 8'h07;
    do_vsync();
    step(200, 200); step(201, 200); step(200, 231);
    drain();
    rom_base[0] = 8'h03;
    step(200, 200); step(205, 210);
    drain();

    // Mid-frame position change is ignored until the next vsync.
    in_x[0] = 10; in_y[0] = 50;
    do_vsync();
    in_x[0] = 20;
    step(15, 50); step(12, 50); step(41, 50); step(42, 50);
    drain();
    do_vsync();
    step(15, 50); step(25, 50); step(51, 50); step(52, 50);
    drain();

    // Right-edge clipping with no coordinate wrap.
    in_x[0] = 1020; in_y[0] = 0; in_x[1] = 2040; in_y[1] = 0;
    do_vsync();
    step(1023, 0); step(5, 0); step(1051, 0); step(1052, 0); step(2047, 31); step(3, 0); step(23, 5);
    drain();

    // Reset asserted mid-line while vsync is high.
    step(1021, 1); step(1022, 2);
    in_x[0] = 300; in_y[0] = 300;
    vsync = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_pixel", 32'(pixel), 32'(BG));
    check("midrst_hit", 32'(hit), 32'(0));
    for (int s = 0; s < NS; s++) check("midrst_addr", 32'(addr_bus[s*AW +: AW]), 32'(0));
    sb.delete(); have_last = 1'b0; check_bg = 1'b1;
    clear_model();
    hcount = 11'(IDLE_H); vcount = 10'(IDLE_V);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step(IDLE_H, IDLE_V);
    vsync = 1'b0;
    repeat (2) step(IDLE_H, IDLE_V);
    step(0, 0); step(5, 5); step(31, 31); step(32, 0);
    drain();

    // Animation: sprite 0 moves then stops; sprite 1 stands still but chops.
    in_x[0] = 100; in_y[0] = 100; in_dir[0] = 2'd0; in_st[0] = 4'd0;
    in_x[1] = 600; in_y[1] = 400; in_dir[1] = 2'd3; in_st[1] = 4'd1;
    rom_base[0] = 8'h11; rom_base[1] = 8'h42;
    for (int k = 1; k <= 40; k++) begin
      do_vsync();
      if (k <= 24) in_x[0] = in_x[0] + 1;
      if (k == 8)  begin probe_frame(0, 1'b1, "frame_move8");  probe_frame(1, 1'b1, "frame_chop8");  end
      if (k == 16) begin probe_frame(0, 1'b0, "frame_move16"); probe_frame(1, 1'b0, "frame_chop16"); end
      if (k == 24) probe_frame(0, 1'b1, "frame_move24");
      if (k == 32) probe_frame(0, 1'b0, "frame_still32");
      if (k == 40) begin probe_frame(0, 1'b0, "frame_still40"); probe_frame(1, 1'b1, "frame_chop40"); end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
